// File: rtl/ntt_polyarith_engine.sv
// Streaming coefficient-wise polynomial arithmetic (MULT/ADD/SUB/MAC mod Q) over a
// single-read/single-write coefficient RAM holding LANES coefficients per word.
module ntt_polyarith_engine #(
  parameter int LANES  = 8,
  parameter int COEF_W = 12,
  parameter int Q      = 3329,
  parameter int N      = 256,
  parameter int ADDR_W = 8,
  parameter int PIPE   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [ADDR_W-1:0]         r_start_offset_A,
  input  logic [ADDR_W-1:0]         r_start_offset_B,
  input  logic [ADDR_W-1:0]         w_data_addr_offset,
  input  logic [LANES*COEF_W-1:0]   r_data,
  output logic [ADDR_W-1:0]         r_data_addr,
  output logic [ADDR_W-1:0]         w_data_addr,
  output logic [LANES*COEF_W-1:0]   w_data,
  output logic                      w_data_en,
  output logic                      busy,
  output logic                      done
);

  localparam int WORDS = N / LANES;
  localparam int DW    = LANES * COEF_W;
  localparam int WI_W  = $clog2(WORDS) + 1;
  localparam int DR_W  = $clog2(PIPE + 1) + 1;
  localparam int D     = (PIPE >= 2) ? PIPE - 1 : 1;
  localparam int PW    = 2 * COEF_W;
  localparam int AW    = COEF_W + 1;
  localparam int RW    = COEF_W + 2;
  localparam int K     = 2 * COEF_W;
  localparam int XM_W  = PW + K + 1;

  localparam logic [K:0]      BAR_M   = (K+1)'((longint'(1) << K) / longint'(Q));
  localparam logic [XM_W-1:0] Q_X     = XM_W'(Q);
  localparam logic [RW-1:0]   Q_R     = RW'(Q);
  localparam logic [RW-1:0]   Q2_R    = RW'(2 * Q);
  localparam logic [AW-1:0]   Q_A     = AW'(Q);
  localparam logic [WI_W-1:0] LAST_WI = WI_W'(WORDS - 1);
  localparam logic [DR_W-1:0] LAST_DR = DR_W'(PIPE);

  typedef enum logic [1:0] {MODE_MULT = 2'd0, MODE_ADD = 2'd1, MODE_SUB = 2'd2, MODE_MAC = 2'd3} mode_t;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  // Barrett reduction with k = 2*COEF_W: the estimate is at most two short of the true
  // quotient, so two conditional subtractions make the result exact.
  function automatic logic [COEF_W-1:0] mod_reduce(input logic [PW-1:0] x);
    logic [XM_W-1:0] xm;
    logic [RW-1:0]   r;
    xm = XM_W'(x) * XM_W'(BAR_M);
    r  = RW'(XM_W'(x) - (xm >> K) * Q_X);
    if (r >= Q2_R)     r = r - Q2_R;
    else if (r >= Q_R) r = r - Q_R;
    return COEF_W'(r);
  endfunction

  state_t              state, state_nxt;
  logic [WI_W-1:0]     wi, wi_nxt;
  logic [1:0]          ph, ph_nxt, ph_last;
  logic [DR_W-1:0]     dr, dr_nxt;
  logic                accept;

  mode_t               mode_q;
  logic [ADDR_W-1:0]   a_base, b_base, w_base;
  logic [ADDR_W-1:0]   rd_addr_nxt;
  logic                rd_vld;
  logic [1:0]          rd_ph;
  logic [WI_W-1:0]     widx;
  logic [DW-1:0]       a_q, b_q, b_op;
  logic                op_fire;

  logic [LANES*PW-1:0] sa_prod, mid_prod;
  logic [LANES*AW-1:0] sa_add, mid_add;
  logic                sa_mul, mid_mul, mid_vld;
  logic [ADDR_W-1:0]   op_addr, mid_addr;
  logic [AW-1:0]       t_lane;
  logic [DW-1:0]       res;

  logic [DW-1:0]       dl_data [D];
  logic [ADDR_W-1:0]   dl_addr [D];
  logic [D-1:0]        dl_vld;

  assign accept  = start && (state == ST_IDLE || state == ST_DONE);
  assign ph_last = (mode_q == MODE_MAC) ? 2'd2 : 2'd1;

  // NOTE: every clocked process uses non-blocking assignments so all registers sample
  // the same pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      wi    <= '0;
      ph    <= '0;
      dr    <= '0;
    end else begin
      state <= state_nxt;
      wi    <= wi_nxt;
      ph    <= ph_nxt;
      dr    <= dr_nxt;
    end
  end

  // NOTE: each combinational output gets a default before the case, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    wi_nxt    = wi;
    ph_nxt    = ph;
    dr_nxt    = dr;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_nxt = ST_RUN;
          wi_nxt    = '0;
          ph_nxt    = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (ph == ph_last) begin
          ph_nxt = '0;
          wi_nxt = wi + WI_W'(1);
          if (wi == LAST_WI) begin
            state_nxt = ST_DRAIN;
            dr_nxt    = '0;
          end
        end else begin
          ph_nxt = ph + 2'd1;
        end
      end
      ST_DRAIN: begin
        if (dr == LAST_DR) state_nxt = ST_DONE;
        else               dr_nxt    = dr + DR_W'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RUN, ST_DRAIN: busy = 1'b1;
      ST_DONE:          done = 1'b1;
      default:          ;
    endcase
  end

  // The read address is registered, so it is derived from the next-cycle counters; the
  // accept cycle uses the raw offset because the base registers load on the same edge.
  always_comb begin
    rd_addr_nxt = '0;
    if (accept) begin
      rd_addr_nxt = r_start_offset_A;
    end else if (state_nxt == ST_RUN) begin
      case (ph_nxt)
        2'd0:    rd_addr_nxt = a_base + ADDR_W'(wi_nxt);
        2'd1:    rd_addr_nxt = b_base + ADDR_W'(wi_nxt);
        default: rd_addr_nxt = w_base + ADDR_W'(wi_nxt);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_MULT;
      a_base      <= '0;
      b_base      <= '0;
      w_base      <= '0;
      r_data_addr <= '0;
      rd_vld      <= 1'b0;
      rd_ph       <= '0;
      widx        <= '0;
    end else begin
      if (accept) begin
        mode_q <= mode_t'(mode);
        a_base <= r_start_offset_A;
        b_base <= r_start_offset_B;
        w_base <= w_data_addr_offset;
      end
      r_data_addr <= rd_addr_nxt;
      rd_vld      <= (state == ST_RUN);
      rd_ph       <= ph;
      if (accept)       widx <= '0;
      else if (op_fire) widx <= widx + WI_W'(1);
    end
  end

  // NOTE: operand holding registers carry no reset; they are always written by a read
  // return before op_fire can consume them, so reset would only cost routing.
  always_ff @(posedge clk) begin
    if (rd_vld && rd_ph == 2'd0) a_q <= r_data;
    if (rd_vld && rd_ph == 2'd1) b_q <= r_data;
  end

  // The last operand of a word is consumed straight off r_data in the cycle it returns.
  assign op_fire = rd_vld && (rd_ph == ph_last);
  assign b_op    = (mode_q == MODE_MAC) ? b_q : r_data;
  assign sa_mul  = (mode_q == MODE_MULT) || (mode_q == MODE_MAC);
  assign op_addr = w_base + ADDR_W'(widx);

  always_comb begin
    sa_prod = '0;
    sa_add  = '0;
    for (int j = 0; j < LANES; j++) begin
      sa_prod[j*PW +: PW] = PW'(a_q[j*COEF_W +: COEF_W]) * PW'(b_op[j*COEF_W +: COEF_W]);
      case (mode_q)
        MODE_ADD: sa_add[j*AW +: AW] = AW'(a_q[j*COEF_W +: COEF_W]) + AW'(b_op[j*COEF_W +: COEF_W]);
        MODE_SUB: sa_add[j*AW +: AW] = AW'(a_q[j*COEF_W +: COEF_W]) + Q_A - AW'(b_op[j*COEF_W +: COEF_W]);
        MODE_MAC: sa_add[j*AW +: AW] = AW'(r_data[j*COEF_W +: COEF_W]);
        default:  sa_add[j*AW +: AW] = '0;
      endcase
    end
  end

  // With PIPE >= 2 the raw product is registered before reduction; PIPE = 1 does all of
  // the arithmetic in the operand cycle.
  generate
    if (PIPE >= 2) begin : g_mid_reg
      always_ff @(posedge clk) begin
        if (rst) mid_vld <= 1'b0;
        else     mid_vld <= op_fire;
      end
      always_ff @(posedge clk) begin
        mid_prod <= sa_prod;
        mid_add  <= sa_add;
        mid_mul  <= sa_mul;
        mid_addr <= op_addr;
      end
    end else begin : g_mid_comb
      always_comb begin
        mid_vld  = op_fire;
        mid_prod = sa_prod;
        mid_add  = sa_add;
        mid_mul  = sa_mul;
        mid_addr = op_addr;
      end
    end
  endgenerate

  // ADD/SUB arrive pre-biased into [0, 2Q), MAC adds c to the reduced product; one
  // conditional subtraction finishes every mode.
  always_comb begin
    res    = '0;
    t_lane = '0;
    for (int j = 0; j < LANES; j++) begin
      t_lane = (mid_mul ? {1'b0, mod_reduce(mid_prod[j*PW +: PW])} : AW'(0)) + mid_add[j*AW +: AW];
      res[j*COEF_W +: COEF_W] = (t_lane >= Q_A) ? COEF_W'(t_lane - Q_A) : COEF_W'(t_lane);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < D; k++) begin
        dl_data[k] <= '0;
        dl_addr[k] <= '0;
        dl_vld[k]  <= 1'b0;
      end
    end else begin
      dl_data[0] <= res;
      dl_addr[0] <= mid_addr;
      dl_vld[0]  <= mid_vld;
      for (int k = 1; k < D; k++) begin
        dl_data[k] <= dl_data[k-1];
        dl_addr[k] <= dl_addr[k-1];
        dl_vld[k]  <= dl_vld[k-1];
      end
    end
  end

  assign w_data      = dl_data[D-1];
  assign w_data_addr = dl_addr[D-1];
  assign w_data_en   = dl_vld[D-1];

endmodule

// File: tb/tb_ntt_polyarith_engine.sv
// Scoreboard bench for ntt_polyarith_engine: a behavioural RAM feeds reads, expected
// writes are queued at launch and popped as the DUT writes.
module tb_ntt_polyarith_engine;

  localparam int LANES = 8;
  localparam int CW    = 12;
  localparam int Q     = 3329;
  localparam int AW    = 8;
  localparam int DW    = LANES * CW;
  localparam int WORDS = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_t;

  logic          clk, rst, start;
  logic [1:0]    mode;
  logic [AW-1:0] r_start_offset_A, r_start_offset_B, w_data_addr_offset;
  logic [DW-1:0] r_data;
  logic [AW-1:0] r_data_addr, w_data_addr;
  logic [DW-1:0] w_data;
  logic          w_data_en, busy, done;

  logic [DW-1:0] mem [256];
  sb_t           sb [$];
  int            n_cmp = 0, n_bad = 0;
  int            cyc = 0, base = 0;
  int            n_wr, first_rel, last_rel, done_cnt, done_rel;
  logic [AW-1:0] first_addr, last_addr;
  logic [DW-1:0] first_data;
  logic [AW-1:0] rd_log [128];

  ntt_polyarith_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .r_start_offset_A(r_start_offset_A), .r_start_offset_B(r_start_offset_B),
    .w_data_addr_offset(w_data_addr_offset), .r_data(r_data),
    .r_data_addr(r_data_addr), .w_data_addr(w_data_addr), .w_data(w_data),
    .w_data_en(w_data_en), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    r_data <= mem[r_data_addr];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    int  rel;
    sb_t e;
    rel = cyc - base;
    if (rel >= 0 && rel < 128) rd_log[rel] = r_data_addr;
    if (w_data_en) begin
      n_wr++;
      if (sb.size() == 0) begin
        check("spurious_wr_en", 128'(w_data_en), 128'(0));
      end else begin
        e = sb.pop_front();
        check("wr_addr", 128'(w_data_addr), 128'(e.addr));
        check("wr_data", 128'(w_data), 128'(e.data));
      end
      if (first_rel < 0) begin
        first_rel  = rel;
        first_addr = w_data_addr;
        first_data = w_data;
      end
      last_rel  = rel;
      last_addr = w_data_addr;
    end
    if (done) begin
      done_cnt++;
      done_rel = rel;
    end
  end

  // Lanes 0..2 take the given values (negative = random); remaining lanes are random.
  task automatic fill(input int addr, input int v0, input int v1, input int v2);
    logic [DW-1:0] w;
    int v;
    for (int j = 0; j < LANES; j++) begin
      v = (j == 0) ? v0 : (j == 1) ? v1 : (j == 2) ? v2 : -1;
      if (v < 0) v = int'($urandom_range(Q - 1));
      w[j*CW +: CW] = CW'(v);
    end
    mem[addr % 256] = w;
  endtask

  function automatic logic [DW-1:0] model(input int md, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [DW-1:0] c);
    logic [DW-1:0] r;
    int av, bv, cv, x;
    for (int j = 0; j < LANES; j++) begin
      av = int'(a[j*CW +: CW]);
      bv = int'(b[j*CW +: CW]);
      cv = int'(c[j*CW +: CW]);
      case (md)
        0:       x = (av * bv) % Q;
        1:       x = (av + bv) % Q;
        2:       x = (av - bv + Q) % Q;
        default: x = ((av * bv) % Q + cv) % Q;
      endcase
      r[j*CW +: CW] = CW'(x);
    end
    return r;
  endfunction

  task automatic launch(input int md, input int a, input int b, input int w);
    sb_t e;
    for (int i = 0; i < WORDS; i++) begin
      e.addr = AW'((w + i) % 256);
      e.data = model(md, mem[(a + i) % 256], mem[(b + i) % 256], mem[(w + i) % 256]);
      sb.push_back(e);
    end
    mode               = 2'(md);
    r_start_offset_A   = AW'(a);
    r_start_offset_B   = AW'(b);
    w_data_addr_offset = AW'(w);
    start              = 1'b1;
    base               = cyc + 1;
    n_wr = 0; first_rel = -1; last_rel = -1; done_cnt = 0; done_rel = -1;
    for (int i = 0; i < 128; i++) rd_log[i] = '0;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("done_seen", 128'(seen), 128'(1));
  endtask

  task automatic wait_rel(input int r);
    int hit;
    hit = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #1;
      if (cyc - base == r) begin
        hit = 1;
        break;
      end
    end
    check("reach_cycle", 128'(hit), 128'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0;
    r_start_offset_A = '0; r_start_offset_B = '0; w_data_addr_offset = '0;
    n_wr = 0; first_rel = -1; last_rel = -1; done_cnt = 0; done_rel = -1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_w_data_en", 128'(w_data_en), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_r_data_addr", 128'(r_data_addr), 128'(0));
    check("rst_w_data_addr", 128'(w_data_addr), 128'(0));
    check("rst_w_data", 128'(w_data), 128'(0));
    @(posedge clk); #2;
    rst = 1'b0;

    // ADD: Q-1 + 1 wraps to 0 in every lane
    for (int i = 0; i < WORDS; i++) begin
      mem[i]      = {LANES{CW'(3328)}};
      mem[32 + i] = {LANES{CW'(1)}};
    end
    launch(1, 0, 32, 64);
    wait_done(200);
    check("add_nwr", 128'(n_wr), 128'(32));
    check("add_done_rel", 128'(done_rel), 128'(67));
    check("add_first_data", 128'(first_data), 128'(0));
    check("add_rd_addr_idle", 128'(r_data_addr), 128'(0));
    check("add_sb_drained", 128'(sb.size()), 128'(0));

    // MULT with timing; a start at cycle 20 must be ignored
    for (int i = 0; i < WORDS; i++) begin
      fill(i, 3328, 1000, 0);
      fill(32 + i, 3328, 2000, 3328);
    end
    launch(0, 0, 32, 64);
    wait_rel(20);
    mode = 2'd2; r_start_offset_A = 8'd200; r_start_offset_B = 8'd210; w_data_addr_offset = 8'd220;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(200);
    check("mul_nwr", 128'(n_wr), 128'(32));
    check("mul_first_rel", 128'(first_rel), 128'(4));
    check("mul_first_addr", 128'(first_addr), 128'(64));
    check("mul_last_rel", 128'(last_rel), 128'(66));
    check("mul_last_addr", 128'(last_addr), 128'(95));
    check("mul_done_rel", 128'(done_rel), 128'(67));
    check("mul_done_cnt", 128'(done_cnt), 128'(1));
    check("mul_busy_in_done", 128'(busy), 128'(0));
    check("mul_lane0", 128'(first_data[0 +: CW]), 128'(1));
    check("mul_lane1", 128'(first_data[CW +: CW]), 128'(2600));
    check("mul_lane2", 128'(first_data[2*CW +: CW]), 128'(0));

    // SUB launched back-to-back in the done cycle
    for (int i = 0; i < WORDS; i++) begin
      fill(128 + i, 0, 5, 3328);
      fill(160 + i, 1, 5, 0);
    end
    launch(2, 128, 160, 192);
    @(negedge clk); #1;
    check("b2b_rel0", 128'(cyc - base), 128'(0));
    check("b2b_busy", 128'(busy), 128'(1));
    check("b2b_done_low", 128'(done), 128'(0));
    check("b2b_rd_addr", 128'(r_data_addr), 128'(128));
    wait_done(200);
    check("sub_nwr", 128'(n_wr), 128'(32));
    check("sub_done_rel", 128'(done_rel), 128'(67));
    check("sub_lane0", 128'(first_data[0 +: CW]), 128'(3328));
    check("sub_lane1", 128'(first_data[CW +: CW]), 128'(0));
    check("sub_lane2", 128'(first_data[2*CW +: CW]), 128'(3328));
    @(negedge clk); #1;
    check("sub_done_pulse", 128'(done), 128'(0));
    check("sub_idle_busy", 128'(busy), 128'(0));

    // MAC: stride 3, read order A,B,W
    for (int i = 0; i < WORDS; i++) begin
      fill(i, 2, -1, -1);
      fill(32 + i, 3, -1, -1);
      fill(64 + i, 3328, -1, -1);
    end
    launch(3, 0, 32, 64);
    wait_done(300);
    check("mac_rd0", 128'(rd_log[0]), 128'(0));
    check("mac_rd1", 128'(rd_log[1]), 128'(32));
    check("mac_rd2", 128'(rd_log[2]), 128'(64));
    check("mac_rd3", 128'(rd_log[3]), 128'(1));
    check("mac_rd4", 128'(rd_log[4]), 128'(33));
    check("mac_rd5", 128'(rd_log[5]), 128'(65));
    check("mac_nwr", 128'(n_wr), 128'(32));
    check("mac_first_rel", 128'(first_rel), 128'(5));
    check("mac_done_rel", 128'(done_rel), 128'(99));
    check("mac_lane0", 128'(first_data[0 +: CW]), 128'(5));

    // Reset in the middle of a run
    launch(0, 0, 32, 64);
    wait_rel(10);
    rst = 1'b1;
    sb.delete();
    @(negedge clk); #1;
    check("mid_rst_wen", 128'(w_data_en), 128'(0));
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_done", 128'(done), 128'(0));
    check("mid_rst_rd_addr", 128'(r_data_addr), 128'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    n_wr = 0;
    repeat (20) @(negedge clk);
    #1;
    check("post_rst_nwr", 128'(n_wr), 128'(0));
    check("post_rst_busy", 128'(busy), 128'(0));

    // Address wrap: A=250, B=10
    for (int i = 0; i < WORDS; i++) begin
      fill(250 + i, -1, -1, -1);
      fill(10 + i, -1, -1, -1);
    end
    launch(1, 250, 10, 100);
    wait_done(200);
    check("wrap_rd14", 128'(rd_log[14]), 128'(1));
    check("wrap_rd15", 128'(rd_log[15]), 128'(17));
    check("wrap_nwr", 128'(n_wr), 128'(32));
    check("wrap_last_addr", 128'(last_addr), 128'(131));
    check("wrap_sb_drained", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
